axis_byte_packer: RTL and testbench

- Downstream consumer of the 8-bit AXIS register stage.
- Packs an 8-bit AXI-Stream into OUT_BYTES-wide words, little-endian: the first byte goes in the lowest lane.
- A word is emitted when it is full, or early when tlast arrives, with tkeep marking the valid lanes.
- Feeds wide-datapath consumers such as DMA and FIFO blocks; also counts completed packets for status.

---
 rtl/axis_byte_packer.sv | 93 +++++++++
 tb/tb_axis_byte_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream into OUT_BYTES-wide little-endian words. A word is emitted
// when it is full or when tlast arrives. Completed packets are counted for status.
module axis_byte_packer #(
   parameter int OUT_BYTES = 4,
   parameter int CNT_W     = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [7:0]             s_axis_tdata,
   input  logic                   s_axis_tvalid,
   input  logic                   s_axis_tlast,
   output logic                   s_axis_tready,
   output logic [8*OUT_BYTES-1:0] m_axis_tdata,
   output logic [OUT_BYTES-1:0]   m_axis_tkeep,
   output logic                   m_axis_tvalid,
   output logic                   m_axis_tlast,
   input  logic                   m_axis_tready,
   output logic [CNT_W-1:0]       pkt_count
);
   localparam int               IDX_W    = $clog2(OUT_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES - 1);

   logic [IDX_W-1:0]       idx;
   logic [8*OUT_BYTES-1:0] acc;
   logic [OUT_BYTES-1:0]   acc_keep;
   logic [8*OUT_BYTES-1:0] new_word;
   logic [OUT_BYTES-1:0]   new_keep;
   logic                   accept;
   logic                   completing;
   logic                   out_hs;

   // Conservative: any byte stalls while the output word is blocked.
   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign completing    = (idx == LAST_IDX) || s_axis_tlast;
   assign out_hs        = m_axis_tvalid && m_axis_tready;

   // Lanes above idx in acc are always zero, so only lane idx needs replacing.
   always_comb begin
      new_word = acc;
      new_keep = acc_keep;
      for (int i = 0; i < OUT_BYTES; i++) begin
         if (IDX_W'(i) == idx) begin
            new_word[8*i +: 8] = s_axis_tdata;
            new_keep[i]        = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         idx      <= '0;
         acc      <= '0;
         acc_keep <= '0;
      end else if (accept) begin
         if (completing) begin
            idx      <= '0;
            acc      <= '0;
            acc_keep <= '0;
         end else begin
            idx                <= idx + 1'b1;
            acc[idx*8 +: 8]    <= s_axis_tdata;
            acc_keep[idx]      <= 1'b1;
         end
      end
   end

   // A completing accept reloads the output even during a handshake: no bubble.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (accept && completing) begin
         m_axis_tdata  <= new_word;
         m_axis_tkeep  <= new_keep;
         m_axis_tvalid <= 1'b1;
         m_axis_tlast  <= s_axis_tlast;
      end else if (out_hs) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_count <= '0;
      end else if (out_hs && m_axis_tlast) begin
         pkt_count <= pkt_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer: directed packets plus randomized streams
// compared against a byte-queue reference model.
module tb_axis_byte_packer;
   localparam int OB = 4;
   localparam int CW = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [7:0]    s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [8*OB-1:0] m_tdata;
   logic [OB-1:0] m_tkeep;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b0;
   logic [CW-1:0] pkt_count;

   axis_byte_packer #(.OUT_BYTES(OB), .CNT_W(CW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .pkt_count(pkt_count)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [8*OB-1:0] d;
      logic [OB-1:0]   k;
      logic            l;
   } word_t;

   word_t         expq[$];
   logic [7:0]    pend[$];
   int            npass = 0;
   int            ntot = 0;
   int            words_seen = 0;
   logic [CW-1:0] cnt_m = '0;
   logic          acc_flag = 1'b0;
   logic          exp_valid_next = 1'b0;
   logic          stall_prev = 1'b0;
   logic [8*OB-1:0] sv_d;
   logic [OB-1:0] sv_k;
   logic          sv_l;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: drive inputs at the falling edge, check, then update the model.
   task automatic step(input logic v, input logic [7:0] b, input logic l, input logic mr);
      word_t w;
      @(negedge aclk);
      s_tvalid = v; s_tdata = b; s_tlast = l; m_tready = mr;
      #1;
      if (stall_prev) begin
         chk("hold_valid", 64'(m_tvalid), 64'(1'b1));
         chk("hold_data", 64'(m_tdata), 64'(sv_d));
         chk("hold_keep", 64'(m_tkeep), 64'(sv_k));
         chk("hold_last", 64'(m_tlast), 64'(sv_l));
      end
      if (exp_valid_next) chk("latency_valid", 64'(m_tvalid), 64'(1'b1));
      chk("pkt_count", 64'(pkt_count), 64'(cnt_m));
      chk("s_tready_rule", 64'(s_tready), 64'(!m_tvalid || m_tready));
      if (m_tvalid) chk("keep_nonzero", 64'(m_tkeep != '0), 64'(1'b1));
      if (m_tvalid && m_tready) begin
         ntot++;
         assert (expq.size() > 0) npass++;
         else $error("FAIL unexpected_word: observed data %0h expected no word", m_tdata);
         if (expq.size() > 0) begin
            w = expq.pop_front();
            chk("word_data", 64'(m_tdata), 64'(w.d));
            chk("word_keep", 64'(m_tkeep), 64'(w.k));
            chk("word_last", 64'(m_tlast), 64'(w.l));
            if (w.l) cnt_m++;
         end
         words_seen++;
      end
      stall_prev = m_tvalid && !m_tready;
      sv_d = m_tdata; sv_k = m_tkeep; sv_l = m_tlast;
      acc_flag = v && s_tready;
      exp_valid_next = 1'b0;
      if (acc_flag) begin
         pend.push_back(b);
         if (pend.size() == OB || l) begin
            w.d = '0;
            for (int i = 0; i < pend.size(); i++) w.d[8*i +: 8] = pend[i];
            w.k = OB'((1 << pend.size()) - 1);
            w.l = l;
            expq.push_back(w);
            pend.delete();
            exp_valid_next = 1'b1;
         end
      end
   endtask

   // Offer one byte until accepted; rnd randomizes both tvalid gaps and m_tready.
   task automatic send(input logic [7:0] b, input logic l, input logic rnd);
      int n = 0;
      do begin
         if (rnd) step(1'($urandom_range(0, 1)), b, l, 1'($urandom_range(0, 1)));
         else     step(1'b1, b, l, 1'b1);
         n++;
      end while (!acc_flag && n < 50);
      if (!acc_flag) chk("send_timeout", 64'(acc_flag), 64'(1'b1));
   endtask

   task automatic drain();
      int n = 0;
      while ((expq.size() > 0 || m_tvalid) && n < 40) begin
         step(1'b0, 8'h00, 1'b0, 1'b1);
         n++;
      end
      chk("drain_empty", 64'(expq.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      logic [7:0] rb;
      repeat (2) @(negedge aclk);
      chk("rst_valid", 64'(m_tvalid), 64'(1'b0));
      chk("rst_last", 64'(m_tlast), 64'(1'b0));
      chk("rst_data", 64'(m_tdata), 64'(0));
      chk("rst_keep", 64'(m_tkeep), 64'(0));
      chk("rst_pkt", 64'(pkt_count), 64'(0));
      aresetn = 1'b1;
      #1 chk("rst_tready", 64'(s_tready), 64'(1'b1));

      // Full 4-byte packet.
      step(1'b1, 8'h11, 1'b0, 1'b1);
      step(1'b1, 8'h22, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b0, 1'b1);
      step(1'b1, 8'h44, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t1_data", 64'(m_tdata), 64'h44332211);
      chk("t1_keep", 64'(m_tkeep), 64'hF);
      chk("t1_last", 64'(m_tlast), 64'(1'b1));
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t1_pkt", 64'(pkt_count), 64'(1));

      // 6-byte packet: one full word then a 2-lane tail.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 8'hA0 + 8'(i), 1'(i == 5), 1'b1);
         if (i == 4) begin
            chk("t2_w0_data", 64'(m_tdata), 64'hA3A2A1A0);
            chk("t2_w0_keep", 64'(m_tkeep), 64'hF);
            chk("t2_w0_last", 64'(m_tlast), 64'(1'b0));
         end
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t2_w1_data", 64'(m_tdata), 64'h0000A5A4);
      chk("t2_w1_keep", 64'(m_tkeep), 64'h3);
      chk("t2_w1_last", 64'(m_tlast), 64'(1'b1));

      // Single-byte packet.
      step(1'b1, 8'h5A, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t3_data", 64'(m_tdata), 64'h0000005A);
      chk("t3_keep", 64'(m_tkeep), 64'h1);
      chk("t3_last", 64'(m_tlast), 64'(1'b1));
      drain();

      // Backpressure: output blocked after first word, input must stall.
      for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'hB4, 1'b0, 1'b0);
         chk("t4_stall_tready", 64'(s_tready), 64'(1'b0));
         chk("t4_stall_data", 64'(m_tdata), 64'hB3B2B1B0);
      end
      for (int i = 4; i < 8; i++) send(8'hB0 + 8'(i), 1'(i == 7), 1'b0);
      drain();

      // Continuous 64-byte stream: a word every 4th cycle, no bubbles.
      w0 = words_seen;
      for (int j = 0; j < 64; j++) begin
         step(1'b1, 8'(j), 1'(j == 63), 1'b1);
         if (j > 0) chk("t5_valid_pattern", 64'(m_tvalid), 64'((j % 4) == 0));
      end
      drain();
      chk("t5_words", 64'(words_seen - w0), 64'(16));

      // Random data, tlast, gaps and downstream readiness.
      for (int j = 0; j < 64; j++) begin
         rb = 8'($urandom);
         send(rb, 1'(j == 63 || $urandom_range(0, 7) == 0), 1'b1);
      end
      drain();

      // Asynchronous reset mid-word discards the partial word and status.
      step(1'b1, 8'hC1, 1'b0, 1'b1);
      step(1'b1, 8'hC2, 1'b0, 1'b1);
      @(negedge aclk);
      s_tvalid = 1'b0;
      #2 aresetn = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(m_tvalid), 64'(1'b0));
      chk("t6_rst_pkt", 64'(pkt_count), 64'(0));
      chk("t6_rst_keep", 64'(m_tkeep), 64'(0));
      pend.delete(); expq.delete();
      cnt_m = '0; stall_prev = 1'b0; exp_valid_next = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'(i == 4), 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t6_data", 64'(m_tdata), 64'h04030201);
      chk("t6_keep", 64'(m_tkeep), 64'hF);
      drain();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
